// File: rtl/dmem_bus_arbiter.sv
// Shares the MEM-stage data bus between the pipeline and a debug/loader port.
// CPU has priority. A starvation counter bounds how long debug can be refused.
module dmem_bus_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter bit DBG_IO_EN = 1'b0
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    input  logic [31:0] bus_rdata,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {CPU_OWN, DBG_XFER, DBG_DONE} state_t;

    localparam logic [3:0] MAX_WAIT_W = 4'(MAX_WAIT);

    state_t      state_reg, state_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic        dbg_ack_reg, dbg_ack_next;
    logic        dbg_err_reg, dbg_err_next;
    logic [31:0] dbg_rdata_reg, dbg_rdata_next;
    logic [15:0] stall_count_reg, stall_count_next;
    logic        dbg_win;
    logic        blocked;

    assign dbg_win = dbg_req & (~cpu_req | (wait_cnt_reg == MAX_WAIT_W));
    // IO space is addr[7]; debug may only reach it when enabled.
    assign blocked = ~DBG_IO_EN & dbg_addr[7];

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        dbg_ack_next   = dbg_ack_reg;
        dbg_err_next   = dbg_err_reg;
        dbg_rdata_next = dbg_rdata_reg;
        bus_addr       = cpu_addr;
        bus_wdata      = cpu_wdata;
        bus_we         = cpu_req & cpu_we;
        cpu_stall      = 1'b0;
        case (state_reg)
            CPU_OWN: begin
                dbg_ack_next = 1'b0;
                dbg_err_next = 1'b0;
                if (dbg_win) begin
                    state_next    = DBG_XFER;
                    wait_cnt_next = 4'd0;
                end else if (dbg_req && (wait_cnt_reg != MAX_WAIT_W)) begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end
            DBG_XFER: begin
                bus_addr       = dbg_addr;
                bus_wdata      = dbg_wdata;
                bus_we         = dbg_we & ~blocked;
                cpu_stall      = cpu_req;
                dbg_rdata_next = blocked ? 32'd0 : bus_rdata;
                dbg_ack_next   = 1'b1;
                dbg_err_next   = blocked;
                state_next     = DBG_DONE;
            end
            DBG_DONE: begin
                // Debug is never granted here, so a lingering dbg_req cannot re-grant.
                dbg_ack_next = 1'b0;
                dbg_err_next = 1'b0;
                state_next   = CPU_OWN;
            end
            default: state_next = CPU_OWN;
        endcase
    end

    always_comb begin
        stall_count_next = stall_count_reg;
        if (cpu_stall && (stall_count_reg != 16'hFFFF))
            stall_count_next = stall_count_reg + 16'd1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= CPU_OWN;
            wait_cnt_reg    <= 4'd0;
            dbg_ack_reg     <= 1'b0;
            dbg_err_reg     <= 1'b0;
            dbg_rdata_reg   <= 32'd0;
            stall_count_reg <= 16'd0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            dbg_ack_reg     <= dbg_ack_next;
            dbg_err_reg     <= dbg_err_next;
            dbg_rdata_reg   <= dbg_rdata_next;
            stall_count_reg <= stall_count_next;
        end
    end

    assign cpu_rdata   = bus_rdata;
    assign dbg_ack     = dbg_ack_reg;
    assign dbg_err     = dbg_err_reg;
    assign dbg_rdata   = dbg_rdata_reg;
    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter with a small RAM/IO model on the shared bus.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_dmem_bus_arbiter;

    logic        clock;
    logic        resetn;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_ack, dbg_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_we;
    logic [15:0] stall_count;

    logic [31:0] ram [0:31];
    logic [31:0] io_reg;

    int total;
    int passed;

    dmem_bus_arbiter #(.MAX_WAIT(4), .DBG_IO_EN(1'b0)) dut (
        .clock(clock), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(bus_rdata),
        .stall_count(stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory-mapped target: RAM words below 0x80, one IO register at/above it.
    assign bus_rdata = bus_addr[7] ? io_reg : ram[bus_addr[6:2]];

    always @(posedge clock) begin
        if (bus_we) begin
            if (bus_addr[7]) io_reg <= bus_wdata;
            else             ram[bus_addr[6:2]] <= bus_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic mid;
        @(negedge clock);
    endtask

    initial begin
        total = 0;
        passed = 0;
        for (int i = 0; i < 32; i++) ram[i] = 32'h0;
        ram[1] = 32'hCAFEF00D;
        io_reg = 32'h00000055;
        resetn = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;

        // Reset state
        mid;
        chk("rst_ack", {31'd0, dbg_ack}, 32'd0);
        chk("rst_err", {31'd0, dbg_err}, 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_stall_count", {16'd0, stall_count}, 32'd0);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        $display("txn reset: ack=%b stall_count=%0d", dbg_ack, stall_count);

        // CPU store 0x1234 to 0x08 with debug idle
        cyc; resetn = 1'b1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h08; cpu_wdata = 32'h1234;
        for (int i = 0; i < 2; i++) begin
            mid;
            chk("st_bus_we", {31'd0, bus_we}, 32'd1);
            chk("st_bus_addr", bus_addr, 32'h08);
            chk("st_stall", {31'd0, cpu_stall}, 32'd0);
            if (i == 0) cyc;
        end
        cyc; cpu_we = 0;
        mid;
        chk("st_readback", cpu_rdata, 32'h1234);
        chk("st_stall_count", {16'd0, stall_count}, 32'd0);
        $display("txn cpu store 0x08<=1234 readback=%h", cpu_rdata);

        // Debug write 0xDEADBEEF to 0x10 with CPU idle
        cyc; cpu_req = 0; cpu_addr = 32'h0;
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h10; dbg_wdata = 32'hDEADBEEF;
        mid;
        chk("dw_decide_stall", {31'd0, cpu_stall}, 32'd0);
        chk("dw_decide_we", {31'd0, bus_we}, 32'd0);
        cyc;
        mid;
        chk("dw_xfer_we", {31'd0, bus_we}, 32'd1);
        chk("dw_xfer_addr", bus_addr, 32'h10);
        chk("dw_xfer_wdata", bus_wdata, 32'hDEADBEEF);
        chk("dw_xfer_ack", {31'd0, dbg_ack}, 32'd0);
        cyc; dbg_req = 0; dbg_we = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        mid;
        chk("dw_done_ack", {31'd0, dbg_ack}, 32'd1);
        chk("dw_done_err", {31'd0, dbg_err}, 32'd0);
        chk("dw_cpu_load", cpu_rdata, 32'hDEADBEEF);
        cyc;
        mid;
        chk("dw_ack_clear", {31'd0, dbg_ack}, 32'd0);
        $display("txn dbg write 0x10<=DEADBEEF cpu load=%h", cpu_rdata);

        // Starvation: CPU loads continuously, debug reads 0x04
        cyc; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h08;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h04;
        for (int i = 0; i < 5; i++) begin
            mid;
            chk("sv_wait_stall", {31'd0, cpu_stall}, 32'd0);
            chk("sv_wait_addr", bus_addr, 32'h08);
            cyc;
        end
        mid;
        chk("sv_xfer_stall", {31'd0, cpu_stall}, 32'd1);
        chk("sv_xfer_addr", bus_addr, 32'h04);
        chk("sv_xfer_we", {31'd0, bus_we}, 32'd0);
        cyc; dbg_req = 0;
        mid;
        chk("sv_done_ack", {31'd0, dbg_ack}, 32'd1);
        chk("sv_done_rdata", dbg_rdata, 32'hCAFEF00D);
        chk("sv_stall_count", {16'd0, stall_count}, 32'd1);
        chk("sv_done_stall", {31'd0, cpu_stall}, 32'd0);
        $display("txn dbg read 0x04 under cpu traffic rdata=%h stall_count=%0d", dbg_rdata, stall_count);

        // Blocked debug IO write to 0x80
        cyc; cpu_req = 0;
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h80; dbg_wdata = 32'hA5A5A5A5;
        cyc;
        mid;
        chk("io_xfer_addr", bus_addr, 32'h80);
        chk("io_xfer_we", {31'd0, bus_we}, 32'd0);
        cyc; dbg_req = 0; dbg_we = 0;
        mid;
        chk("io_ack", {31'd0, dbg_ack}, 32'd1);
        chk("io_err", {31'd0, dbg_err}, 32'd1);
        chk("io_rdata", dbg_rdata, 32'd0);
        chk("io_unchanged", io_reg, 32'h55);
        cyc;
        mid;
        chk("io_err_clear", {31'd0, dbg_err}, 32'd0);
        $display("txn dbg io write 0x80 err=%b io=%h", dbg_err, io_reg);

        // dbg_req held through DBG_DONE must not re-grant there
        cyc; cpu_req = 0; cpu_addr = 32'h0C;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h08;
        cyc;
        mid;
        chk("b2b_xfer1_addr", bus_addr, 32'h08);
        cyc;
        mid;
        chk("b2b_done_ack", {31'd0, dbg_ack}, 32'd1);
        chk("b2b_done_addr", bus_addr, 32'h0C);
        cyc;
        mid;
        chk("b2b_arb_addr", bus_addr, 32'h0C);
        chk("b2b_arb_ack", {31'd0, dbg_ack}, 32'd0);
        cyc;
        mid;
        chk("b2b_xfer2_addr", bus_addr, 32'h08);
        cyc; dbg_req = 0;
        mid;
        chk("b2b_done2_ack", {31'd0, dbg_ack}, 32'd1);
        $display("txn back-to-back dbg reads of 0x08 rdata=%h", dbg_rdata);

        // Reset pulsed during DBG_XFER
        cyc; cpu_req = 0; cpu_addr = 32'h18;
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h14; dbg_wdata = 32'h77;
        cyc; cpu_req = 1;
        mid;
        chk("rx_xfer_stall", {31'd0, cpu_stall}, 32'd1);
        chk("rx_pre_count", {16'd0, stall_count}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("rx_ack", {31'd0, dbg_ack}, 32'd0);
        chk("rx_count", {16'd0, stall_count}, 32'd0);
        chk("rx_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rx_addr", bus_addr, 32'h18);
        cyc; resetn = 1'b1; dbg_req = 0; dbg_we = 0;
        for (int i = 0; i < 3; i++) begin
            mid;
            chk("rx_no_ack", {31'd0, dbg_ack}, 32'd0);
            cyc;
        end
        $display("txn reset during xfer: ack=%b stall_count=%0d", dbg_ack, stall_count);

        // After reset wait_cnt starts from 0: forced grant lands on cycle 5 again
        dbg_req = 1; dbg_addr = 32'h04;
        for (int i = 0; i < 5; i++) begin
            mid;
            chk("rw_wait_stall", {31'd0, cpu_stall}, 32'd0);
            cyc;
        end
        mid;
        chk("rw_xfer_stall", {31'd0, cpu_stall}, 32'd1);
        cyc; dbg_req = 0;
        mid;
        chk("rw_done_ack", {31'd0, dbg_ack}, 32'd1);
        chk("rw_count", {16'd0, stall_count}, 32'd1);
        $display("txn post-reset dbg read 0x04 rdata=%h", dbg_rdata);

        cyc;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
Shares the MEM-stage data bus (data RAM plus memory-mapped IO, where addr[7]=1 selects IO) between the pipeline MEM stage and a debug/loader port. The CPU has priority. The debug port gets a bounded-latency grant through a starvation counter. The CPU is stalled only in cycles it loses arbitration. The block sits between the MEM-stage pipeline registers and the RAM/IO mux block.

Parameters:
MAX_WAIT, 4, cycles dbg_req may be refused before debug is force-granted (1..15)
DBG_IO_EN, 0, 1 = debug port may access IO space; 0 = IO accesses from debug are blocked

Ports:
clock  in  1  single system clock, rising edge
resetn  in  1  asynchronous active-low reset
cpu_req  in  1  MEM stage performs load or store this cycle
cpu_we  in  1  MEM stage store (mwmem)
cpu_addr  in  32  MEM-stage address (malu)
cpu_wdata  in  32  MEM-stage store data (mb)
cpu_rdata  out  32  read data to MEM stage (mmo)
cpu_stall  out  1  freeze PC/IF/ID/EX/MEM registers this cycle
dbg_req  in  1  debug request, level, held until dbg_ack
dbg_we  in  1  debug write
dbg_addr  in  32  debug address
dbg_wdata  in  32  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  32  registered debug read data, valid with dbg_ack
dbg_err  out  1  pulses with dbg_ack when an IO access was blocked
bus_addr  out  32  shared address to RAM/IO
bus_wdata  out  32  shared write data
bus_we  out  1  shared write enable
bus_rdata  in  32  shared read data, valid same cycle as bus_addr
stall_count  out  16  saturating count of CPU stall cycles

Behaviour:
- FSM states are CPU_OWN, DBG_XFER and DBG_DONE. Reset state is CPU_OWN.
- Reset values (asynchronous, immediate): dbg_ack=0, dbg_err=0, dbg_rdata=0, stall_count=0, wait_cnt=0.
- Winner in CPU_OWN is decided combinationally in the current cycle:
  - dbg wins if dbg_req & (~cpu_req | wait_cnt==MAX_WAIT).
  - Otherwise CPU owns the bus.
  - dbg win moves the FSM to DBG_XFER at the next edge.
- Bus mux in CPU_OWN and DBG_DONE: bus = cpu_*, bus_we = cpu_req & cpu_we.
- Bus mux in DBG_XFER:
  - bus = dbg_*, bus_we = dbg_we.
  - bus_we is forced 0 when DBG_IO_EN=0 and dbg_addr[7]=1.
- DBG_XFER lasts exactly 1 cycle:
  - cpu_stall = cpu_req.
  - dbg_rdata <= bus_rdata, or 0 if blocked.
  - dbg_ack <= 1, dbg_err <= blocked.
  - Next state is DBG_DONE.
- DBG_DONE lasts exactly 1 cycle:
  - dbg_ack=1.
  - Debug may not be granted, so a still-high dbg_req is ignored.
  - CPU uses the bus.
  - Next state is CPU_OWN. dbg_ack/dbg_err clear at the following edge.
- Debug-win cycle in CPU_OWN: the forced grant takes effect in DBG_XFER, not in the deciding cycle. cpu_stall is 0 in the deciding cycle.
- cpu_stall is 1 only in DBG_XFER with cpu_req=1. While stalled, the CPU holds cpu_* stable.
- cpu_rdata = bus_rdata, combinational pass-through. It is meaningful only when not stalled.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each CPU_OWN cycle with dbg_req=1 and CPU winning.
  - Clears on entering DBG_XFER.
  - Holds in DBG_DONE.
- stall_count increments each cycle cpu_stall=1 and saturates at 16'hFFFF.
- Maximum debug latency: MAX_WAIT+1 cycles from dbg_req to DBG_XFER under continuous CPU traffic.
- Back-to-back debug: the minimum spacing between two DBG_XFER cycles is 2 cycles (the DBG_DONE cycle plus at least one CPU_OWN arbitration cycle).
- Reset asserted mid-transfer: the transfer is abandoned and no ack is issued. A write already presented with bus_we may or may not have committed.
- Simultaneous cpu_req, dbg_req with wait_cnt<MAX_WAIT: CPU wins, no stall, wait_cnt+1.

Test Plan:
- Idle debug, CPU stores 0x1234 to addr 0x08 -> bus_we=1, bus_addr=0x08, cpu_stall=0 every cycle, stall_count stays 0.
- cpu_req=0, dbg_req write 0xDEADBEEF to 0x10 -> DBG_XFER next cycle with bus_we=1. dbg_ack high 1 cycle later. A subsequent CPU load of 0x10 returns 0xDEADBEEF.
- cpu_req held high continuously, dbg_req read of 0x04 at cycle 0, MAX_WAIT=4 -> wait_cnt 1..4 over cycles 0..3. Cycle 4 is the forced-win decision with cpu_stall=0. DBG_XFER at cycle 5 with cpu_stall=1, dbg_ack at cycle 6, stall_count=1.
- DBG_IO_EN=0, debug write to 0x80 -> bus_we=0 in DBG_XFER, dbg_err=1 with dbg_ack, dbg_rdata=0, IO output unchanged.
- dbg_req kept high through DBG_DONE -> no second grant in DBG_DONE. The next grant occurs no earlier than the cycle after DBG_DONE.
- resetn pulsed low during DBG_XFER -> immediate CPU_OWN, dbg_ack=0, stall_count=0, wait_cnt=0. No ack is issued after release.
